// File: rtl/battleship_board_if.sv
// Controller <-> player-board bundle: setup/load strobes and display code out, status back.
interface battleship_board_if;
    logic       st;
    logic       ld_ships;
    logic       ld_attack;
    logic [2:0] disp_code;
    logic       ok;
    logic       liv;
    logic       hit;

    modport master (output st, ld_ships, ld_attack, disp_code, input ok, liv, hit);
    modport slave  (input st, ld_ships, ld_attack, disp_code, output ok, liv, hit);
endinterface

// File: rtl/battleship_board.sv
// Per-player Battleship board: ship/attack/received-hit maps, attack validity, LED drive.
// Optional macro BS_SHIP_COUNT_CHECK_EN enforces NUM_SHIPS ship cells during setup.
module battleship_board #(
    parameter int N          = 16,
    parameter int NUM_SHIPS  = 4,
    parameter int ERR_CYCLES = 50000000
) (
    input  logic                     clk,
    input  logic                     clr_n,
    battleship_board_if.slave        ctrl,
    input  logic [N-1:0]             i_sw,
    input  logic [N-1:0]             i_opp_shot,
    output logic [N-1:0]             o_shot_new,
    output logic [N-1:0]             o_led
);

    localparam int CW = (ERR_CYCLES < 2) ? 1 : $clog2(ERR_CYCLES + 1);
    localparam logic [CW-1:0] ERR_LOAD = CW'(ERR_CYCLES);
    localparam logic [2:0] DISP_SETUP = 3'd0;
    localparam logic [2:0] DISP_OWN   = 3'd1;
    localparam logic [2:0] DISP_HITS  = 3'd2;
    localparam logic [2:0] DISP_ERR   = 3'd5;

`ifdef BS_SHIP_COUNT_CHECK_EN
    localparam bit SHIP_CHECK = 1'b1;
`else
    localparam bit SHIP_CHECK = 1'b0;
`endif

    logic [N-1:0]  r_ships;
    logic [N-1:0]  r_attack;
    logic [N-1:0]  r_rcvd;
    logic [N-1:0]  r_hits;
    logic [N-1:0]  r_shot_new;
    logic [N-1:0]  r_led;
    logic          r_ok;
    logic          r_liv;
    logic          r_hit;
    logic [CW-1:0] r_err_cnt;

    logic [N-1:0]  w_new_bits;
    logic [N-1:0]  w_rcvd_next;
    logic          w_keep;
    logic          w_setup_ok;
    logic          w_ok_next;
    logic          w_setup_load;
    logic          w_commit;
    logic          w_shot_in;

    // A legal attack keeps every committed cell and adds exactly one new one.
    assign w_new_bits   = i_sw & ~r_attack;
    assign w_keep       = (i_sw & r_attack) == r_attack;
    assign w_setup_ok   = !SHIP_CHECK || ($countones(i_sw) == NUM_SHIPS);
    assign w_ok_next    = ctrl.st ? w_setup_ok
                                  : (w_keep && ($countones(w_new_bits) == 1));
    assign w_setup_load = ctrl.st && ctrl.ld_ships && (!SHIP_CHECK || r_ok);
    assign w_commit     = !ctrl.st && ctrl.ld_attack && r_ok;
    assign w_shot_in    = !ctrl.st && ctrl.ld_ships;
    assign w_rcvd_next  = r_rcvd | i_opp_shot;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_ok  <= 1'b0;
            r_liv <= 1'b0;
            r_hit <= 1'b0;
        end else begin
            r_ok  <= w_ok_next;
            r_liv <= |(r_ships & ~r_hits);
            r_hit <= w_shot_in && |(i_opp_shot & r_ships);
        end
    end

    // Ships only change on a setup load, which also clears rcvd, so hits == rcvd & ships.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_ships    <= '0;
            r_attack   <= '0;
            r_rcvd     <= '0;
            r_hits     <= '0;
            r_shot_new <= '0;
        end else if (w_setup_load) begin
            r_ships    <= i_sw;
            r_attack   <= '0;
            r_rcvd     <= '0;
            r_hits     <= '0;
            r_shot_new <= '0;
        end else begin
            if (w_commit) begin
                r_attack   <= i_sw;
                r_shot_new <= w_new_bits;
            end
            if (w_shot_in) begin
                r_rcvd <= w_rcvd_next;
                r_hits <= w_rcvd_next & r_ships;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_err_cnt <= '0;
        end else if (ctrl.disp_code == DISP_ERR) begin
            r_err_cnt <= ERR_LOAD;
        end else if (w_commit) begin
            r_err_cnt <= '0;
        end else if (r_err_cnt != '0) begin
            r_err_cnt <= r_err_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_led <= '0;
        end else if (r_err_cnt != '0) begin
            r_led <= {N{1'b1}};
        end else begin
            case (ctrl.disp_code)
                DISP_SETUP: r_led <= i_sw;
                DISP_OWN:   r_led <= i_sw;
                DISP_HITS:  r_led <= r_hits;
                default:    r_led <= '0;
            endcase
        end
    end

    assign ctrl.ok    = r_ok;
    assign ctrl.liv   = r_liv;
    assign ctrl.hit   = r_hit;
    assign o_shot_new = r_shot_new;
    assign o_led      = r_led;

endmodule

// File: tb/tb_battleship_board.sv
// Scoreboard bench for battleship_board: expected values queued at drive time, popped at sample time.
module tb_battleship_board;

    localparam int N = 16;
    localparam int ERR_CYCLES = 8;

    logic         clk = 1'b0;
    logic         clrN;
    logic [N-1:0] sw;
    logic [N-1:0] oppShot;
    logic [N-1:0] shotNew;
    logic [N-1:0] led;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] expQ[$];

    battleship_board_if bif();

    battleship_board #(.N(N), .NUM_SHIPS(4), .ERR_CYCLES(ERR_CYCLES)) dut (
        .clk        (clk),
        .clr_n      (clrN),
        .ctrl       (bif.slave),
        .i_sw       (sw),
        .i_opp_shot (oppShot),
        .o_shot_new (shotNew),
        .o_led      (led)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [N-1:0] e;
        clrN = 1'b0;
        sw = 16'h1234;
        oppShot = '0;
        bif.st = 1'b0;
        bif.ld_ships = 1'b0;
        bif.ld_attack = 1'b0;
        bif.disp_code = 3'd1;
        tick();
        tick();
        expQ.push_back(16'h0000);
        expQ.push_back(16'h0000);
        e = expQ.pop_front();
        checks++;
        if (led !== e) begin errors++; $display("[TB] FAIL reset_led: got %h expected %h", led, e); end
        e = expQ.pop_front();
        checks++;
        if (shotNew !== e) begin errors++; $display("[TB] FAIL reset_shot_new: got %h expected %h", shotNew, e); end
        checks++;
        if (bif.ok !== 1'b0) begin errors++; $display("[TB] FAIL reset_ok: got %b expected 0", bif.ok); end
        checks++;
        if (bif.liv !== 1'b0) begin errors++; $display("[TB] FAIL reset_liv: got %b expected 0", bif.liv); end
        checks++;
        if (bif.hit !== 1'b0) begin errors++; $display("[TB] FAIL reset_hit: got %b expected 0", bif.hit); end
        clrN = 1'b1;
        sw = '0;
    endtask

    task automatic test_setup();
        bif.st = 1'b1;
        bif.disp_code = 3'd0;
`ifdef BS_SHIP_COUNT_CHECK_EN
        sw = 16'h0007;
        tick();
        checks++;
        if (bif.ok !== 1'b0) begin errors++; $display("[TB] FAIL setup_count_ok: got %b expected 0", bif.ok); end
        bif.ld_ships = 1'b1;
        tick();
        bif.ld_ships = 1'b0;
        tick();
        tick();
        checks++;
        if (bif.liv !== 1'b0) begin errors++; $display("[TB] FAIL setup_count_ignored: got %b expected 0", bif.liv); end
`endif
        sw = 16'h000F;
        tick();
        checks++;
        if (bif.ok !== 1'b1) begin errors++; $display("[TB] FAIL setup_ok: got %b expected 1", bif.ok); end
        bif.ld_ships = 1'b1;
        tick();
        bif.ld_ships = 1'b0;
        checks++;
        if (bif.liv !== 1'b0) begin errors++; $display("[TB] FAIL setup_liv_lag: got %b expected 0", bif.liv); end
        expQ.push_back(16'h000F);
        tick();
        checks++;
        if (bif.liv !== 1'b1) begin errors++; $display("[TB] FAIL setup_liv: got %b expected 1", bif.liv); end
        begin
            logic [N-1:0] e;
            e = expQ.pop_front();
            checks++;
            if (led !== e) begin errors++; $display("[TB] FAIL setup_led: got %h expected %h", led, e); end
        end
    endtask

    task automatic test_valid_attack();
        logic [N-1:0] e;
        logic [N-1:0] swSeq [2] = '{16'h0001, 16'h0003};
        logic [N-1:0] shotSeq [2] = '{16'h0001, 16'h0002};
        bif.st = 1'b0;
        bif.disp_code = 3'd1;
        for (int i = 0; i < 2; i++) begin
            sw = swSeq[i];
            tick();
            checks++;
            if (bif.ok !== 1'b1) begin errors++; $display("[TB] FAIL attack_ok_%0d: got %b expected 1", i, bif.ok); end
            bif.ld_attack = 1'b1;
            expQ.push_back(shotSeq[i]);
            tick();
            bif.ld_attack = 1'b0;
            e = expQ.pop_front();
            checks++;
            if (shotNew !== e) begin errors++; $display("[TB] FAIL attack_shot_%0d: got %h expected %h", i, shotNew, e); end
        end
        expQ.push_back(16'h0003);
        tick();
        checks++;
        if (bif.ok !== 1'b0) begin errors++; $display("[TB] FAIL attack_no_new_ok: got %b expected 0", bif.ok); end
        e = expQ.pop_front();
        checks++;
        if (led !== e) begin errors++; $display("[TB] FAIL attack_led: got %h expected %h", led, e); end
    endtask

    task automatic test_invalid_attack();
        logic [N-1:0] e;
        logic [N-1:0] swSeq [3] = '{16'h000F, 16'h0005, 16'h0007};
        logic expOk [3] = '{1'b0, 1'b0, 1'b1};
        logic [N-1:0] shotSeq [3] = '{16'h0002, 16'h0002, 16'h0004};
        for (int i = 0; i < 3; i++) begin
            sw = swSeq[i];
            tick();
            checks++;
            if (bif.ok !== expOk[i]) begin errors++; $display("[TB] FAIL invalid_ok_%0d: got %b expected %b", i, bif.ok, expOk[i]); end
            bif.ld_attack = 1'b1;
            expQ.push_back(shotSeq[i]);
            tick();
            bif.ld_attack = 1'b0;
            e = expQ.pop_front();
            checks++;
            if (shotNew !== e) begin errors++; $display("[TB] FAIL invalid_shot_%0d: got %h expected %h", i, shotNew, e); end
        end
    endtask

    task automatic test_hits();
        logic [N-1:0] e;
        logic [N-1:0] shipsM = 16'h000F;
        logic [N-1:0] hitsM = '0;
        logic [N-1:0] shots [6] = '{16'h0001, 16'h0002, 16'h0010, 16'h0001, 16'h0004, 16'h0008};
        bif.disp_code = 3'd2;
        for (int i = 0; i < 6; i++) begin
            oppShot = shots[i];
            bif.ld_ships = 1'b1;
            expQ.push_back({15'd0, |(shots[i] & shipsM)});
            expQ.push_back({15'd0, |(shipsM & ~hitsM)});
            hitsM = hitsM | (shots[i] & shipsM);
            tick();
            bif.ld_ships = 1'b0;
            oppShot = '0;
            e = expQ.pop_front();
            checks++;
            if (bif.hit !== e[0]) begin errors++; $display("[TB] FAIL hit_pulse_%0d: got %b expected %b", i, bif.hit, e[0]); end
            e = expQ.pop_front();
            checks++;
            if (bif.liv !== e[0]) begin errors++; $display("[TB] FAIL hit_liv_%0d: got %b expected %b", i, bif.liv, e[0]); end
            expQ.push_back({15'd0, |(shipsM & ~hitsM)});
            expQ.push_back(hitsM);
            tick();
            checks++;
            if (bif.hit !== 1'b0) begin errors++; $display("[TB] FAIL hit_idle_%0d: got %b expected 0", i, bif.hit); end
            e = expQ.pop_front();
            checks++;
            if (bif.liv !== e[0]) begin errors++; $display("[TB] FAIL hit_liv_idle_%0d: got %b expected %b", i, bif.liv, e[0]); end
            e = expQ.pop_front();
            checks++;
            if (led !== e) begin errors++; $display("[TB] FAIL hit_led_%0d: got %h expected %h", i, led, e); end
        end
    endtask

    task automatic test_error();
        logic [N-1:0] e;
        sw = 16'h00A5;
        bif.disp_code = 3'd5;
        tick();
        bif.disp_code = 3'd1;
        for (int k = 1; k <= ERR_CYCLES + 1; k++) begin
            expQ.push_back((k <= ERR_CYCLES) ? 16'hFFFF : 16'h00A5);
            tick();
            e = expQ.pop_front();
            checks++;
            if (led !== e) begin errors++; $display("[TB] FAIL err_led_%0d: got %h expected %h", k, led, e); end
        end
        bif.disp_code = 3'd5;
        tick();
        for (int k = 1; k <= ERR_CYCLES + 5; k++) begin
            bif.disp_code = (k == 4) ? 3'd5 : 3'd1;
            expQ.push_back((k <= ERR_CYCLES + 4) ? 16'hFFFF : 16'h00A5);
            tick();
            e = expQ.pop_front();
            checks++;
            if (led !== e) begin errors++; $display("[TB] FAIL err_reload_led_%0d: got %h expected %h", k, led, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] e;
        bif.st = 1'b1;
        bif.disp_code = 3'd0;
        sw = 16'h00F0;
        tick();
        bif.ld_ships = 1'b1;
        tick();
        bif.ld_ships = 1'b0;
        bif.st = 1'b0;
        sw = 16'h0100;
        tick();
        checks++;
        if (bif.ok !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ok: got %b expected 1", bif.ok); end
        bif.ld_attack = 1'b1;
        bif.ld_ships = 1'b1;
        oppShot = 16'h0010;
        expQ.push_back(16'h0100);
        tick();
        bif.ld_attack = 1'b0;
        bif.ld_ships = 1'b0;
        oppShot = '0;
        e = expQ.pop_front();
        checks++;
        if (shotNew !== e) begin errors++; $display("[TB] FAIL b2b_shot: got %h expected %h", shotNew, e); end
        checks++;
        if (bif.hit !== 1'b1) begin errors++; $display("[TB] FAIL b2b_hit: got %b expected 1", bif.hit); end
        tick();
        checks++;
        if (bif.liv !== 1'b1) begin errors++; $display("[TB] FAIL b2b_liv: got %b expected 1", bif.liv); end
    endtask

    task automatic test_reset_midplay();
        logic [N-1:0] e;
        sw = 16'h0000;
        bif.disp_code = 3'd0;
        @(posedge clk);
        #2;
        clrN = 1'b0;
        #1;
        expQ.push_back(16'h0000);
        e = expQ.pop_front();
        checks++;
        if (shotNew !== e) begin errors++; $display("[TB] FAIL midreset_shot: got %h expected %h", shotNew, e); end
        checks++;
        if (bif.liv !== 1'b0) begin errors++; $display("[TB] FAIL midreset_liv: got %b expected 0", bif.liv); end
        checks++;
        if (bif.ok !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ok: got %b expected 0", bif.ok); end
        checks++;
        if (led !== 16'h0000) begin errors++; $display("[TB] FAIL midreset_led: got %h expected 0000", led); end
        @(negedge clk);
        clrN = 1'b1;
        tick();
        tick();
        checks++;
        if (bif.liv !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ships_cleared: got %b expected 0", bif.liv); end
    endtask

    initial begin
        test_reset();
        test_setup();
        test_valid_attack();
        test_invalid_attack();
        test_hits();
        test_error();
        test_back_to_back();
        test_reset_midplay();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
